eq_gain_ctrl: RTL and testbench

Consumes the 12-bit one-hot/pulse bus button_ord from the touch button decoder. Maintains the user-facing equalizer state: three band gains, master volume and mute. Pushes each changed setting, one item at a time, to the coefficient loader over a valid/ready handshake. Also drives the gain, volume and mute levels shown by the display overlay.

---
 rtl/eq_gain_ctrl_pkg.sv | 47 ++++
 rtl/eq_gain_ctrl_if.sv | 25 ++
 rtl/eq_gain_ctrl_limiter.sv | 41 ++++
 rtl/eq_gain_ctrl.sv | 166 ++++++++++++++++
 tb/tb_eq_gain_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eq_gain_ctrl_pkg.sv
// Shared constants for the equalizer user-interface block: button bit
// positions, saturation defaults, config item ids and handshake FSM states.
package eq_ui_pkg;

    // Bit positions on the button_ord bus
    localparam int BTN_UP0   = 0;
    localparam int BTN_UP1   = 1;
    localparam int BTN_UP2   = 2;
    localparam int BTN_DN0   = 3;
    localparam int BTN_DN1   = 4;
    localparam int BTN_DN2   = 5;
    localparam int BTN_ZERO0 = 6;
    localparam int BTN_ZERO1 = 7;
    localparam int BTN_ZERO2 = 8;
    localparam int BTN_MUTE  = 9;
    localparam int BTN_VOLDN = 10;
    localparam int BTN_VOLUP = 11;
    localparam int BTN_W     = 12;

    // Default saturation limits
    localparam int GAIN_MAX_DEF = 12;
    localparam int GAIN_MIN_DEF = -12;
    localparam int VOL_MAX_DEF  = 63;

    // Config item ids sent to the coefficient loader
    localparam logic [1:0] CFG_SEL_BAND0 = 2'd0;
    localparam logic [1:0] CFG_SEL_BAND1 = 2'd1;
    localparam logic [1:0] CFG_SEL_BAND2 = 2'd2;
    localparam logic [1:0] CFG_SEL_VOL   = 2'd3;

    // Handshake FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Index of the lowest set bit; callers only use it when some bit is set
    function automatic logic [1:0] lowest_set(input logic [3:0] bits);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bits[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/eq_gain_ctrl_if.sv
// Valid/ready config channel from the equalizer UI to the coefficient loader.
interface eq_gain_ctrl_if;

    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_data;

    // UI side produces items
    modport master (
        output cfg_valid,
        output cfg_sel,
        output cfg_data,
        input  cfg_ready
    );

    // Loader side consumes items
    modport slave (
        input  cfg_valid,
        input  cfg_sel,
        input  cfg_data,
        output cfg_ready
    );

endinterface

// File: rtl/eq_gain_ctrl_limiter.sv
// Auto-repeat limiter for the two held volume buttons. A single countdown
// timer gates both directions so a held button steps at most once per
// REPEAT_CYC cycles, and the first press steps immediately.
module btn_repeat_limiter #(
    parameter int REPEAT_CYC = 2500000
) (
    input  logic pclk,
    input  logic rst,
    input  logic vol_up_lvl,
    input  logic vol_dn_lvl,
    output logic step_up,
    output logic step_dn
);

    localparam int TMR_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(REPEAT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    logic [TMR_W-1:0] timer;
    logic             timer_idle;
    logic             both_held;

    assign timer_idle = (timer == '0);
    assign both_held  = vol_up_lvl && vol_dn_lvl;

    // Both buttons together cancel each other, so only a lone button steps
    assign step_up = vol_up_lvl && !vol_dn_lvl && timer_idle;
    assign step_dn = vol_dn_lvl && !vol_up_lvl && timer_idle;

    // Reload on every step, otherwise count down; holding both freezes it
    always_ff @(posedge pclk) begin
        if (rst) begin
            timer <= '0;
        end else if (step_up || step_dn) begin
            timer <= TMR_LOAD;
        end else if (!both_held && !timer_idle) begin
            timer <= timer - TMR_ONE;
        end
    end

endmodule

// File: rtl/eq_gain_ctrl.sv
// Equalizer user-interface state: three band gains, master volume and mute,
// driven by decoded touch buttons. Every setting that actually changes is
// marked dirty and pushed to the coefficient loader one item at a time.
module eq_gain_ctrl
    import eq_ui_pkg::*;
#(
    parameter int GAIN_W     = 5,
    parameter int GAIN_MAX   = GAIN_MAX_DEF,
    parameter int GAIN_MIN   = GAIN_MIN_DEF,
    parameter int VOL_W      = 6,
    parameter int VOL_MAX    = VOL_MAX_DEF,
    parameter int VOL_RST    = 32,
    parameter int REPEAT_CYC = 2500000
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic [BTN_W-1:0]         button_ord,
    output logic signed [GAIN_W-1:0] gain0,
    output logic signed [GAIN_W-1:0] gain1,
    output logic signed [GAIN_W-1:0] gain2,
    output logic [VOL_W-1:0]         volume,
    output logic                     mute,
    eq_gain_ctrl_if.master           cfg
);

    localparam logic signed [GAIN_W-1:0] G_MAX = GAIN_W'(GAIN_MAX);
    localparam logic signed [GAIN_W-1:0] G_MIN = GAIN_W'(GAIN_MIN);
    localparam logic signed [GAIN_W-1:0] G_ONE = GAIN_W'(1);
    localparam logic [VOL_W-1:0]         V_MAX = VOL_W'(VOL_MAX);
    localparam logic [VOL_W-1:0]         V_RST = VOL_W'(VOL_RST);
    localparam logic [VOL_W-1:0]         V_ONE = VOL_W'(1);

    logic signed [GAIN_W-1:0] gain_q [3];
    logic signed [GAIN_W-1:0] gain_d [3];
    logic [2:0]               band_chg;
    logic [VOL_W-1:0]         vol_q;
    logic [VOL_W-1:0]         vol_d;
    logic                     vol_chg;
    logic                     mute_q;
    logic                     mute_tog;
    logic                     step_up;
    logic                     step_dn;
    logic [3:0]               set_dirty;

    logic [0:0]               state;
    logic [3:0]               dirty;
    logic [3:0]               dirty_clr;
    logic [1:0]               pick_sel;
    logic [7:0]               pick_data;
    logic [1:0]               sel_q;
    logic [7:0]               data_q;

    btn_repeat_limiter #(
        .REPEAT_CYC (REPEAT_CYC)
    ) u_limiter (
        .pclk       (pclk),
        .rst        (rst),
        .vol_up_lvl (button_ord[BTN_VOLUP]),
        .vol_dn_lvl (button_ord[BTN_VOLDN]),
        .step_up    (step_up),
        .step_dn    (step_dn)
    );

    // Next band gains: zero beats up/down, opposing presses cancel, ends saturate
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            gain_d[k] = gain_q[k];
            if (button_ord[BTN_ZERO0 + k]) begin
                gain_d[k] = '0;
            end else if (button_ord[BTN_UP0 + k] && !button_ord[BTN_DN0 + k]) begin
                if (gain_q[k] < G_MAX) begin
                    gain_d[k] = gain_q[k] + G_ONE;
                end
            end else if (button_ord[BTN_DN0 + k] && !button_ord[BTN_UP0 + k]) begin
                if (gain_q[k] > G_MIN) begin
                    gain_d[k] = gain_q[k] - G_ONE;
                end
            end
            band_chg[k] = (gain_d[k] != gain_q[k]);
        end
    end

    // Next volume from the limiter's step pulses, clamped to 0..VOL_MAX
    always_comb begin
        vol_d = vol_q;
        if (step_up && (vol_q < V_MAX)) begin
            vol_d = vol_q + V_ONE;
        end else if (step_dn && (vol_q != '0)) begin
            vol_d = vol_q - V_ONE;
        end
        vol_chg = (vol_d != vol_q);
    end

    assign mute_tog  = button_ord[BTN_MUTE];
    assign set_dirty = {mute_tog | vol_chg, band_chg};

    // User-visible settings registers
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                gain_q[k] <= '0;
            end
            vol_q  <= V_RST;
            mute_q <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                gain_q[k] <= gain_d[k];
            end
            vol_q  <= vol_d;
            mute_q <= mute_q ^ mute_tog;
        end
    end

    assign gain0  = gain_q[0];
    assign gain1  = gain_q[1];
    assign gain2  = gain_q[2];
    assign volume = vol_q;
    assign mute   = mute_q;

    // Pick the lowest pending item and snapshot its payload for launch from IDLE
    always_comb begin
        pick_sel  = lowest_set(dirty);
        dirty_clr = '0;
        case (pick_sel)
            CFG_SEL_BAND0: pick_data = 8'(gain_q[0]);
            CFG_SEL_BAND1: pick_data = 8'(gain_q[1]);
            CFG_SEL_BAND2: pick_data = 8'(gain_q[2]);
            default:       pick_data = {mute_q, 1'b0, 6'(vol_q)};
        endcase
        if ((state == ST_IDLE) && (dirty != '0)) begin
            dirty_clr[pick_sel] = 1'b1;
        end
    end

    // Handshake FSM and dirty tracking; a fresh change beats the launch clear
    always_ff @(posedge pclk) begin
        if (rst) begin
            state  <= ST_IDLE;
            dirty  <= 4'b1111;
            sel_q  <= CFG_SEL_BAND0;
            data_q <= '0;
        end else begin
            dirty <= (dirty & ~dirty_clr) | set_dirty;
            case (state)
                ST_IDLE: begin
                    if (dirty != '0) begin
                        sel_q  <= pick_sel;
                        data_q <= pick_data;
                        state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (cfg.cfg_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cfg.cfg_valid = (state == ST_SEND);
    assign cfg.cfg_sel   = sel_q;
    assign cfg.cfg_data  = data_q;

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Self-checking bench for eq_gain_ctrl: a behavioural model tracks the
// settings and the config channel cycle by cycle, a recorder logs every
// accepted transfer, and directed scenarios pin known values.
module tb_eq_gain_ctrl;

    localparam int RC    = 16;
    localparam int G_MAX = 12;
    localparam int G_MIN = -12;
    localparam int V_MAX = 63;
    localparam int V_RST = 32;

    logic              pclk = 1'b0;
    logic              rst  = 1'b1;
    logic [11:0]       button_ord = '0;
    logic signed [4:0] gain0, gain1, gain2;
    logic [5:0]        volume;
    logic              mute;

    eq_gain_ctrl_if cfg ();

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_gain [3];
    int m_vol   = V_RST;
    int m_mute  = 0;
    int m_cool  = 0;
    bit m_dirty [4];
    int m_valid = 0;
    int m_sel   = 0;
    int m_data  = 0;

    typedef struct {
        int sel;
        int data;
    } xfer_t;
    xfer_t xq [$];

    always #5 pclk = ~pclk;

    eq_gain_ctrl #(
        .GAIN_W     (5),
        .GAIN_MAX   (G_MAX),
        .GAIN_MIN   (G_MIN),
        .VOL_W      (6),
        .VOL_MAX    (V_MAX),
        .VOL_RST    (V_RST),
        .REPEAT_CYC (RC)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .button_ord (button_ord),
        .gain0      (gain0),
        .gain1      (gain1),
        .gain2      (gain2),
        .volume     (volume),
        .mute       (mute),
        .cfg        (cfg)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] btn, input logic rdy, input logic r, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge pclk);
            button_ord    = btn;
            cfg.cfg_ready = rdy;
            rst           = r;
        end
    endtask

    function automatic int payload(input int k);
        logic [7:0] b;
        if (k < 3) begin
            b = m_gain[k][7:0];
            return int'(b);
        end
        return m_mute * 128 + m_vol;
    endfunction

    task automatic model_step();
        int  nv;
        bit  up, dn, found;
        if (rst) begin
            for (int k = 0; k < 3; k++) m_gain[k] = 0;
            for (int k = 0; k < 4; k++) m_dirty[k] = 1'b1;
            m_vol = V_RST; m_mute = 0; m_cool = 0;
            m_valid = 0; m_sel = 0; m_data = 0;
            return;
        end
        // config channel uses the settings as they were before this edge
        if (m_valid == 0) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && m_dirty[k]) begin
                    found = 1'b1;
                    m_sel = k;
                    m_data = payload(k);
                    m_dirty[k] = 1'b0;
                    m_valid = 1;
                end
            end
        end else if (cfg.cfg_ready) begin
            m_valid = 0;
        end
        for (int k = 0; k < 3; k++) begin
            up = button_ord[k];
            dn = button_ord[3 + k];
            nv = m_gain[k];
            if (button_ord[6 + k]) nv = 0;
            else if (up && !dn) nv = (nv + 1 > G_MAX) ? G_MAX : nv + 1;
            else if (dn && !up) nv = (nv - 1 < G_MIN) ? G_MIN : nv - 1;
            if (nv != m_gain[k]) begin
                m_gain[k] = nv;
                m_dirty[k] = 1'b1;
            end
        end
        if (button_ord[9]) begin
            m_mute = 1 - m_mute;
            m_dirty[3] = 1'b1;
        end
        up = button_ord[11];
        dn = button_ord[10];
        if (up != dn) begin
            if (m_cool == 0) begin
                m_cool = RC - 1;
                nv = up ? ((m_vol < V_MAX) ? m_vol + 1 : m_vol) : ((m_vol > 0) ? m_vol - 1 : m_vol);
                if (nv != m_vol) begin
                    m_vol = nv;
                    m_dirty[3] = 1'b1;
                end
            end else begin
                m_cool--;
            end
        end else if (!up && m_cool > 0) begin
            m_cool--;
        end
    endtask

    // Advance the model on the same edge the design samples
    always @(posedge pclk) begin
        model_step();
    end

    // Log every accepted config item
    always @(posedge pclk) begin
        if (!rst && cfg.cfg_valid && cfg.cfg_ready) begin
            xq.push_back('{int'(cfg.cfg_sel), int'(cfg.cfg_data)});
        end
    end

    // Compare all outputs with the model on every falling edge
    always @(negedge pclk) begin
        checkOutput("gain0",     int'(gain0),         m_gain[0]);
        checkOutput("gain1",     int'(gain1),         m_gain[1]);
        checkOutput("gain2",     int'(gain2),         m_gain[2]);
        checkOutput("volume",    int'(volume),        m_vol);
        checkOutput("mute",      int'(mute),          m_mute);
        checkOutput("cfg_valid", int'(cfg.cfg_valid), m_valid);
        checkOutput("cfg_sel",   int'(cfg.cfg_sel),   m_sel);
        checkOutput("cfg_data",  int'(cfg.cfg_data),  m_data);
    end

    task automatic checkDefaults();
        checkOutput("default_count", xq.size(), 4);
        if (xq.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("default_sel", xq[k].sel, k);
                checkOutput("default_data", xq[k].data, (k == 3) ? 32'h20 : 0);
            end
        end
    endtask

    initial begin
        logic [11:0] b;
        int          lv;
        cfg.cfg_ready = 1'b1;
        for (int k = 0; k < 3; k++) m_gain[k] = 0;

        // Reset, then the four default items go out in order
        applyStimulus(12'h000, 1'b1, 1'b1, 3);
        xq.delete();
        applyStimulus(12'h000, 1'b1, 1'b0, 12);
        checkDefaults();
        applyStimulus(12'h000, 1'b1, 1'b0, 6);
        checkOutput("idle_valid", int'(cfg.cfg_valid), 0);
        checkOutput("idle_count", xq.size(), 4);

        // Thirteen band0 up pulses saturate at +12 after twelve transfers
        xq.delete();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(12'h001, 1'b1, 1'b0, 1);
            applyStimulus(12'h000, 1'b1, 1'b0, 3);
        end
        applyStimulus(12'h000, 1'b1, 1'b0, 4);
        checkOutput("sat_gain0", int'(gain0), 12);
        checkOutput("sat_count", xq.size(), 12);
        if (xq.size() > 0) checkOutput("sat_last_data", xq[xq.size() - 1].data, 8'h0C);

        // Zero band0, step it down, then cancelled band1 press with zero
        applyStimulus(12'h040, 1'b1, 1'b0, 1);
        applyStimulus(12'h000, 1'b1, 1'b0, 4);
        xq.delete();
        applyStimulus(12'h008, 1'b1, 1'b0, 1);
        applyStimulus(12'h000, 1'b1, 1'b0, 4);
        applyStimulus(12'h090, 1'b1, 1'b0, 1);
        applyStimulus(12'h000, 1'b1, 1'b0, 4);
        checkOutput("neg_gain0", int'(gain0), -1);
        checkOutput("neg_gain1", int'(gain1), 0);
        checkOutput("neg_count", xq.size(), 1);
        if (xq.size() == 1) begin
            checkOutput("neg_sel", xq[0].sel, 0);
            checkOutput("neg_data", xq[0].data, 8'hFF);
        end

        // Held volume-up steps once per RC cycles; both held does nothing
        applyStimulus(12'h800, 1'b1, 1'b0, 3 * RC + 10);
        applyStimulus(12'h000, 1'b1, 1'b0, RC + 2);
        checkOutput("vol_held", int'(volume), 36);
        applyStimulus(12'hC00, 1'b1, 1'b0, 20);
        applyStimulus(12'h000, 1'b1, 1'b0, 4);
        checkOutput("vol_both", int'(volume), 36);

        // Stalled loader: item held stable, band0 re-changed and resent first
        xq.delete();
        applyStimulus(12'h003, 1'b0, 1'b0, 1);
        applyStimulus(12'h000, 1'b0, 1'b0, 3);
        applyStimulus(12'h001, 1'b0, 1'b0, 1);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(12'h000, 1'b0, 1'b0, 1);
            checkOutput("stall_valid", int'(cfg.cfg_valid), 1);
            checkOutput("stall_sel", int'(cfg.cfg_sel), 0);
            checkOutput("stall_data", int'(cfg.cfg_data), 0);
        end
        applyStimulus(12'h000, 1'b1, 1'b0, 10);
        checkOutput("stall_count", xq.size(), 3);
        if (xq.size() == 3) begin
            checkOutput("stall_x0_sel", xq[0].sel, 0);
            checkOutput("stall_x0_data", xq[0].data, 0);
            checkOutput("stall_x1_sel", xq[1].sel, 0);
            checkOutput("stall_x1_data", xq[1].data, 1);
            checkOutput("stall_x2_sel", xq[2].sel, 1);
            checkOutput("stall_x2_data", xq[2].data, 1);
        end

        // Mute in flight, then reset mid-transfer
        applyStimulus(12'h200, 1'b0, 1'b0, 1);
        applyStimulus(12'h000, 1'b0, 1'b0, 3);
        checkOutput("mute_valid", int'(cfg.cfg_valid), 1);
        checkOutput("mute_sel", int'(cfg.cfg_sel), 3);
        checkOutput("mute_data", int'(cfg.cfg_data), 164);
        applyStimulus(12'h000, 1'b0, 1'b1, 1);
        applyStimulus(12'h000, 1'b1, 1'b0, 1);
        checkOutput("rst_valid", int'(cfg.cfg_valid), 0);
        checkOutput("rst_mute", int'(mute), 0);
        checkOutput("rst_volume", int'(volume), 32);
        xq.delete();
        applyStimulus(12'h000, 1'b1, 1'b0, 12);
        checkDefaults();

        // Randomized traffic against the model
        lv = 0;
        for (int i = 0; i < 3000; i++) begin
            b = '0;
            if ($urandom_range(0, 5) == 0) begin
                b[9:0] = 10'($urandom) & 10'($urandom);
                if (i < 1000) b[5:3] = 3'b000;
                else if (i < 2000) b[2:0] = 3'b000;
            end
            if ($urandom_range(0, 39) == 0) lv = $urandom_range(0, 3);
            b[11:10] = 2'(lv);
            applyStimulus(b, ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0), 1);
        end
        applyStimulus(12'h000, 1'b1, 1'b0, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
